mem_2_axi4_lite: RTL and testbench



---
 rtl/axi4_lite_pkg.sv | 14 +
 rtl/mem_2_axi4_lite.sv | 198 +++++++++++++++++++
 tb/tb_mem_2_axi4_lite.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and default protection bits.
// Used by both the master and the slave memory bridges.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/mem_2_axi4_lite.sv
// Memory-style requester to AXI4-Lite master bridge, one transaction in flight.
// Define MEM_2_AXI4_LITE_WSTRB_EN to add the mem_wstrb byte-enable input.
module mem_2_axi4_lite
    import axi4_lite_pkg::*;
#(
    parameter int ALEN     = 10,
    parameter int DLEN     = 32,
    parameter int AXI_ALEN = 32
) (
    input  logic                clk,
    input  logic                rstn,

    output logic                mem_ready,
    input  logic                mem_wen,
    input  logic [ALEN-1:0]     mem_waddr,
    input  logic [DLEN-1:0]     mem_wdata,
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
    input  logic [DLEN/8-1:0]   mem_wstrb,
`endif
    input  logic                mem_ren,
    input  logic [ALEN-1:0]     mem_raddr,
    output logic [DLEN-1:0]     mem_rdata,
    output logic                mem_rvalid,
    output logic                mem_wdone,
    output logic                mem_err,

    output logic [AXI_ALEN-1:0] awaddr,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,

    output logic [DLEN-1:0]     wdata,
    output logic [DLEN/8-1:0]   wstrb,
    output logic                wvalid,
    input  logic                wready,

    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,

    output logic [AXI_ALEN-1:0] araddr,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,

    input  logic [DLEN-1:0]     rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);

    localparam int SLEN = DLEN / 8;
    localparam int OFFW = $clog2(SLEN);

    if ((DLEN % 8) != 0) begin : g_dlen_chk
        $error("DLEN must be a multiple of 8");
    end
    if (AXI_ALEN < ALEN + OFFW) begin : g_alen_chk
        $error("AXI_ALEN too small for ALEN word addresses");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_AW,
        WR_W,
        WR_B,
        RD_A,
        RD_R
    } state_e;

    state_e            state_q, state_d;
    logic [ALEN-1:0]   addr_q, addr_d;
    logic [DLEN-1:0]   wdata_q, wdata_d;
    logic [DLEN-1:0]   rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              wdone_q, wdone_d;
    logic              err_q, err_d;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
    logic [SLEN-1:0]   wstrb_q, wstrb_d;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
            wstrb_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            err_q    <= err_d;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
            wstrb_q  <= wstrb_d;
`endif
        end
    end

    // AW and W complete independently; WR_B is reached once both are done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_wen)      state_d = WR;
                else if (mem_ren) state_d = RD_A;
            end
            WR: begin
                if (awready && wready) state_d = WR_B;
                else if (awready)      state_d = WR_W;
                else if (wready)       state_d = WR_AW;
            end
            WR_AW:   if (awready) state_d = WR_B;
            WR_W:    if (wready)  state_d = WR_B;
            WR_B:    if (bvalid)  state_d = IDLE;
            RD_A:    if (arready) state_d = RD_R;
            RD_R:    if (rvalid)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;
        err_d    = 1'b0;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
        wstrb_d  = wstrb_q;
`endif
        if (state_q == IDLE) begin
            if (mem_wen) begin
                addr_d  = mem_waddr;
                wdata_d = mem_wdata;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
                wstrb_d = mem_wstrb;
`endif
            end else if (mem_ren) begin
                addr_d = mem_raddr;
            end
        end
        if (state_q == WR_B && bvalid) begin
            wdone_d = 1'b1;
            err_d   = resp_t'(bresp) != OKAY;
        end
        if (state_q == RD_R && rvalid) begin
            rvalid_d = 1'b1;
            rdata_d  = rdata;
            err_d    = resp_t'(rresp) != OKAY;
        end
    end

    always_comb begin
        mem_ready = state_q == IDLE;
        awvalid   = state_q == WR || state_q == WR_AW;
        wvalid    = state_q == WR || state_q == WR_W;
        bready    = state_q == WR_B;
        arvalid   = state_q == RD_A;
        rready    = state_q == RD_R;
    end

    assign awaddr     = AXI_ALEN'(addr_q) << OFFW;
    assign araddr     = AXI_ALEN'(addr_q) << OFFW;
    assign awprot     = PROT_DEFAULT;
    assign arprot     = PROT_DEFAULT;
    assign wdata      = wdata_q;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
    assign wstrb      = wstrb_q;
`else
    assign wstrb      = '1;
`endif
    assign mem_rdata  = rdata_q;
    assign mem_rvalid = rvalid_q;
    assign mem_wdone  = wdone_q;
    assign mem_err    = err_q;

    a_aw_stable: assert property (@(posedge clk) disable iff (!rstn)
        awvalid && !awready |=> awvalid && $stable(awaddr));
    a_w_stable: assert property (@(posedge clk) disable iff (!rstn)
        wvalid && !wready |=> wvalid && $stable(wdata) && $stable(wstrb));
    a_ar_stable: assert property (@(posedge clk) disable iff (!rstn)
        arvalid && !arready |=> arvalid && $stable(araddr));
    a_idle_quiet: assert property (@(posedge clk) disable iff (!rstn)
        state_q == IDLE |-> !(awvalid || wvalid || arvalid));
    a_done_excl: assert property (@(posedge clk) disable iff (!rstn)
        !(mem_rvalid && mem_wdone));

endmodule

// File: tb/tb_mem_2_axi4_lite.sv
// Bench for mem_2_axi4_lite: responsive AXI slave plus a latency/payload model.
// Honours MEM_2_AXI4_LITE_WSTRB_EN to match the DUT build.
module tb_mem_2_axi4_lite;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_ready;
    logic        mem_wen;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ren;
    logic [9:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_wdone;
    logic        mem_err;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_2_axi4_lite dut (
        .clk        (clk),
        .rstn       (rstn),
        .mem_ready  (mem_ready),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
        .mem_wstrb  (mem_wstrb),
`endif
        .mem_ren    (mem_ren),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_wdone  (mem_wdone),
        .mem_err    (mem_err),
        .awaddr     (awaddr),
        .awprot     (awprot),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .araddr     (araddr),
        .arprot     (arprot),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    task automatic slave_idle();
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        arready = 1'b0;
        rvalid  = 1'b0;
        rresp   = 2'b00;
        rdata   = 32'h0;
    endtask

    // Entered and left at posedge+1; cycle 0 is the request cycle.
    task automatic run_write(input string nm, input logic [9:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly,
                             input int b_dly, input logic [1:0] resp,
                             input bit with_rd);
        logic [31:0] exp_addr;
        logic [3:0]  exp_s;
        int t_done, b_at, nb;
        bit aw_ok, w_ok;
        exp_addr = 32'(a) * 4;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
        exp_s = s;
`else
        exp_s = 4'hF;
`endif
        t_done = 1 + (aw_dly > w_dly ? aw_dly : w_dly) + 2 + b_dly;
        checks++;
        if (mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s.ready got=%b exp=1", nm, mem_ready);
        end
        mem_wen = 1'b1; mem_waddr = a; mem_wdata = d; mem_wstrb = s;
        if (with_rd) begin
            mem_ren = 1'b1; mem_raddr = ~a;
        end
        aw_ok = 0; w_ok = 0; b_at = -1; nb = 0;
        @(posedge clk); #1;
        mem_wen = 1'b0; mem_ren = 1'b0;
        for (int c = 1; c <= t_done; c++) begin
            if (c == t_done) begin
                checks++;
                if (mem_wdone !== 1'b1 || mem_rvalid !== 1'b0 ||
                    mem_err !== (resp != 2'b00) || mem_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL %s.done got=wd%b rv%b err%b rdy%b exp=wd1 rv0 err%b rdy1",
                             nm, mem_wdone, mem_rvalid, mem_err, mem_ready, resp != 2'b00);
                end
                checks++;
                if (nb !== 1 || mem_rdata !== last_rdata) begin
                    failures++;
                    $display("FAIL %s.bcount_rdata got=%0d/%h exp=1/%h",
                             nm, nb, mem_rdata, last_rdata);
                end
                break;
            end
            checks++;
            if (mem_wdone !== 1'b0 || mem_rvalid !== 1'b0 || mem_err !== 1'b0 ||
                arvalid !== 1'b0) begin
                failures++;
                $display("FAIL %s.quiet c=%0d got=wd%b rv%b err%b arv%b exp=0",
                         nm, c, mem_wdone, mem_rvalid, mem_err, arvalid);
            end
            checks++;
            if (awvalid !== !aw_ok || wvalid !== !w_ok ||
                bready !== (aw_ok && w_ok)) begin
                failures++;
                $display("FAIL %s.valids c=%0d got=aw%b w%b b%b exp=aw%b w%b b%b",
                         nm, c, awvalid, wvalid, bready, !aw_ok, !w_ok, aw_ok && w_ok);
            end
            if (awvalid) begin
                checks++;
                if (awaddr !== exp_addr || awprot !== 3'b000) begin
                    failures++;
                    $display("FAIL %s.awaddr c=%0d got=%h exp=%h", nm, c, awaddr, exp_addr);
                end
            end
            if (wvalid) begin
                checks++;
                if (wdata !== d || wstrb !== exp_s) begin
                    failures++;
                    $display("FAIL %s.wdata c=%0d got=%h/%b exp=%h/%b",
                             nm, c, wdata, wstrb, d, exp_s);
                end
            end
            awready = (c >= 1 + aw_dly);
            wready  = (c >= 1 + w_dly);
            if (aw_ok && w_ok && b_at < 0) b_at = c + b_dly;
            bvalid = (b_at >= 0) && (c >= b_at) && (nb == 0);
            bresp  = resp;
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            if (bvalid && bready) nb++;
            @(posedge clk); #1;
        end
        slave_idle();
    endtask

    task automatic run_read(input string nm, input logic [9:0] a,
                            input logic [31:0] d, input int ar_dly,
                            input int r_dly, input logic [1:0] resp);
        logic [31:0] exp_addr;
        int t_done, r_at;
        bit ar_ok, r_ok;
        exp_addr = 32'(a) * 4;
        t_done = 1 + ar_dly + 2 + r_dly;
        checks++;
        if (mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s.ready got=%b exp=1", nm, mem_ready);
        end
        mem_ren = 1'b1; mem_raddr = a;
        ar_ok = 0; r_ok = 0; r_at = -1;
        @(posedge clk); #1;
        mem_ren = 1'b0;
        for (int c = 1; c <= t_done; c++) begin
            if (c == t_done) begin
                checks++;
                if (mem_rvalid !== 1'b1 || mem_wdone !== 1'b0 || mem_rdata !== d ||
                    mem_err !== (resp != 2'b00) || mem_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL %s.done got=rv%b wd%b d=%h err%b rdy%b exp=rv1 wd0 d=%h err%b rdy1",
                             nm, mem_rvalid, mem_wdone, mem_rdata, mem_err, mem_ready,
                             d, resp != 2'b00);
                end
                last_rdata = d;
                break;
            end
            checks++;
            if (mem_wdone !== 1'b0 || mem_rvalid !== 1'b0 || mem_err !== 1'b0 ||
                awvalid !== 1'b0 || wvalid !== 1'b0 || mem_rdata !== last_rdata) begin
                failures++;
                $display("FAIL %s.quiet c=%0d got=wd%b rv%b err%b aw%b w%b d=%h",
                         nm, c, mem_wdone, mem_rvalid, mem_err, awvalid, wvalid, mem_rdata);
            end
            checks++;
            if (arvalid !== !ar_ok || rready !== ar_ok) begin
                failures++;
                $display("FAIL %s.valids c=%0d got=ar%b r%b exp=ar%b r%b",
                         nm, c, arvalid, rready, !ar_ok, ar_ok);
            end
            if (arvalid) begin
                checks++;
                if (araddr !== exp_addr || arprot !== 3'b000) begin
                    failures++;
                    $display("FAIL %s.araddr c=%0d got=%h exp=%h", nm, c, araddr, exp_addr);
                end
            end
            arready = (c >= 1 + ar_dly);
            if (ar_ok && r_at < 0) r_at = c + r_dly;
            rvalid = (r_at >= 0) && (c >= r_at) && !r_ok;
            rdata  = rvalid ? d : ~d;
            rresp  = resp;
            if (arvalid && arready) ar_ok = 1;
            if (rvalid && rready) r_ok = 1;
            @(posedge clk); #1;
        end
        slave_idle();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        mem_wen = 1'b0; mem_ren = 1'b0;
        mem_waddr = '0; mem_raddr = '0; mem_wdata = '0; mem_wstrb = '0;
        slave_idle();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_ready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0 ||
            bready !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin
            failures++;
            $display("FAIL reset.ctrl got=rdy%b aw%b w%b b%b ar%b r%b exp=rdy1 rest0",
                     mem_ready, awvalid, wvalid, bready, arvalid, rready);
        end
        checks++;
        if (mem_rvalid !== 1'b0 || mem_wdone !== 1'b0 || mem_err !== 1'b0 ||
            mem_rdata !== 32'h0 || awaddr !== 32'h0 || wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset.data got=rv%b wd%b err%b d=%h aa=%h wd=%h exp=0",
                     mem_rvalid, mem_wdone, mem_err, mem_rdata, awaddr, wdata);
        end
        #1 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_basic();
        run_write("wr_basic", 10'h005, 32'hDEADBEEF, 4'b0101, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic test_aw_delay();
        run_write("wr_awdly", 10'h123, 32'h01234567, 4'b1111, 4, 0, 0, 2'b00, 0);
        run_write("wr_wdly", 10'h0F0, 32'h89ABCDEF, 4'b0011, 0, 3, 1, 2'b11, 0);
    endtask

    task automatic test_read_err();
        run_read("rd_err", 10'h3FF, 32'hA5A5A5A5, 2, 0, 2'b10);
        run_read("rd_ok", 10'h000, 32'h5A5A0F0F, 0, 2, 2'b00);
    endtask

    task automatic test_collision();
        run_write("wr_coll", 10'h2AA, 32'hCAFEF00D, 4'b1000, 1, 0, 0, 2'b00, 1);
        run_read("rd_retry", 10'h155, 32'h13579BDF, 0, 0, 2'b00);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [9:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            logic [1:0]  r;
            a = 10'($urandom);
            d = $urandom;
            s = 4'($urandom);
            r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                run_write("wr_rand", a, d, s, $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2), r, 0);
            else
                run_read("rd_rand", a, d, $urandom_range(0, 3),
                         $urandom_range(0, 3), r);
        end
    endtask

    task automatic test_reset_in_wrb();
        mem_wen = 1'b1; mem_waddr = 10'h0AA; mem_wdata = 32'h11223344;
        @(posedge clk); #1;
        mem_wen = 1'b0; awready = 1'b1; wready = 1'b1;
        @(posedge clk); #1;
        awready = 1'b0; wready = 1'b0;
        checks++;
        if (bready !== 1'b1) begin
            failures++;
            $display("FAIL rst_wrb.bready got=%b exp=1", bready);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 ||
            mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_wrb.async got=aw%b w%b b%b rdy%b exp=0 0 0 1",
                     awvalid, wvalid, bready, mem_ready);
        end
        @(posedge clk); #2 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_wdone !== 1'b0 || bready !== 1'b0 || mem_ready !== 1'b1) begin
                failures++;
                $display("FAIL rst_wrb.after got=wd%b b%b rdy%b exp=0 0 1",
                         mem_wdone, bready, mem_ready);
            end
        end
        last_rdata = 32'h0;
        run_write("wr_post_rst", 10'h001, 32'h0BADF00D, 4'b0001, 0, 0, 0, 2'b00, 0);
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_aw_delay();
        test_read_err();
        test_collision();
        test_back_to_back();
        test_reset_in_wrb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
